// File: rtl/fsk_frame_decoder.sv
// fsk_frame_decoder
//   Recovers Hamming code words from a serial FSK line. Each bit occupies a
//   fixed window of BIT_LEN clock cycles; a '1' toggles the line faster than
//   a '0', so the bit is decided by counting line edges inside the window.
//   Words are WORD_LEN bits, MSB first. An edge-free stretch of IDLE_TIMEOUT
//   cycles marks the line as idle; mid-frame this aborts the frame.
//
// Ports
//   quickclk   in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   fskin      in   serial FSK line, asynchronous, idles low
//   code       out  last complete word, MSB = first bit received
//   code_valid out  one-cycle strobe, code is new on this cycle
//   frame_err  out  one-cycle strobe, frame aborted by idle timeout
//   busy       out  high while a frame is being received or drained
module fsk_frame_decoder #(
  parameter int BIT_LEN      = 64,
  parameter int HALF1        = 4,
  parameter int HALF0        = 8,
  parameter int EDGE_THRESH  = 12,
  parameter int IDLE_TIMEOUT = 32,
  parameter int WORD_LEN     = 11
) (
  input  logic                quickclk,
  input  logic                reset,
  input  logic                fskin,
  output logic [WORD_LEN-1:0] code,
  output logic                code_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int PH_W = $clog2(BIT_LEN);
  localparam int EC_W = $clog2(BIT_LEN + 1);
  localparam int BN_W = $clog2(WORD_LEN);
  localparam int QW   = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // The threshold must sit between the nominal '0' and '1' edge counts, and
  // the idle timeout must exceed the longest gap between edges of a '0'.
  if (IDLE_TIMEOUT <= 2 * HALF0 || EDGE_THRESH > BIT_LEN / HALF1 ||
      EDGE_THRESH <= BIT_LEN / HALF0) begin : g_param_check
    $error("fsk_frame_decoder: inconsistent timing parameters");
  end

  // Cycles since the last edge, saturating at the timeout value.
  function automatic logic [QW-1:0] quiet_next(input logic [QW-1:0] q,
                                               input logic e);
    if (e)                            return '0;
    else if (q == QW'(IDLE_TIMEOUT))  return q;
    else                              return q + QW'(1);
  endfunction

  logic                sync1_q, sync2_q, prev_q;
  logic [1:0]          state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [EC_W-1:0]     edges_q, edges_d;
  logic [BN_W-1:0]     bitn_q, bitn_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic [WORD_LEN-1:0] shift_q, shift_d;
  logic [WORD_LEN-1:0] code_q, code_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic                edge_s;
  logic                timeout;
  logic                bit_val;
  logic [EC_W-1:0]     edges_now;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge quickclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= fskin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_s    = sync2_q ^ prev_q;
  assign edges_now = edges_q + EC_W'(edge_s);
  assign bit_val   = (edges_now >= EC_W'(EDGE_THRESH));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    edges_d = edges_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    quiet_d = quiet_next(quiet_q, edge_s);
    timeout = (quiet_d == QW'(IDLE_TIMEOUT));

    case (state_q)
      S_IDLE: begin
        // The first edge of a frame is phase 0 of bit 0 and already counts.
        if (edge_s) begin
          state_d = S_RECV;
          phase_d = PH_W'(1);
          edges_d = EC_W'(1);
          bitn_d  = '0;
          shift_d = '0;
        end
      end
      S_RECV: begin
        // Timeout takes priority over a decision falling on the same cycle.
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (phase_q == PH_W'(BIT_LEN - 1)) begin
          shift_d = {shift_q[WORD_LEN-2:0], bit_val};
          phase_d = '0;
          edges_d = '0;
          if (bitn_q == BN_W'(WORD_LEN - 1)) begin
            code_d  = {shift_q[WORD_LEN-2:0], bit_val};
            valid_d = 1'b1;
            bitn_d  = '0;
            state_d = S_WAIT;
          end else begin
            bitn_d = bitn_q + BN_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
          edges_d = edges_now;
        end
      end
      S_WAIT: begin
        // Edges only keep the line busy; a new frame needs a full idle gap.
        if (timeout) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge quickclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      edges_q <= '0;
      bitn_q  <= '0;
      quiet_q <= '0;
      shift_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      edges_q <= edges_d;
      bitn_q  <= bitn_d;
      quiet_q <= quiet_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
